// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, per-round rotation
// amounts and the schedule FSM state type.
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 28;
  localparam int SK_W     = 48;
  localparam int N_ROUNDS = 16;

  // Entries are 1-based DES bit numbers of the source vector (bit 1 = MSB).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] ENC_SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Decrypt starts at K16, whose cumulative shift of 28 is the identity.
  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {IDLE, EMIT} state_t;

  // Bit 27 holds DES bit 1 of the half, so a DES left shift is a rotate toward the MSB.
  function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotl28 = {x[CD_W-2:0], x[CD_W-1]};
      2'd2:    rotl28 = {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
      default: rotl28 = x;
    endcase
  endfunction

  function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotr28 = {x[0], x[CD_W-1:1]};
      2'd2:    rotr28 = {x[1:0], x[CD_W-1:2]};
      default: rotr28 = x;
    endcase
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression of the 56-bit C||D state to a 48-bit round subkey; pure wiring,
// shared with the round-function key-mix stage.
module des_pc2
  import des_pkg::*;
(
  input  logic [2*CD_W-1:0] cd,
  output logic [SK_W-1:0]   subkey
);

  always_comb begin
    subkey = '0;
    for (int i = 0; i < SK_W; i++) begin
      subkey[SK_W-1-i] = cd[2*CD_W-PC2[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: emits K1..K16 (or K16..K1) one per valid/ready
// handshake, rotating C and D in place instead of storing subkeys.
module des_key_schedule
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic             decrypt,
  output logic             busy,
  output logic             sk_valid,
  input  logic             sk_ready,
  output logic [SK_W-1:0]  subkey,
  output logic [3:0]       sk_round,
  output logic             sk_last
);

  state_t          state;
  logic [CD_W-1:0] c;
  logic [CD_W-1:0] d;
  logic [3:0]      round;
  logic            dir;
  logic            valid_q;
  logic            last_q;

  logic [2*CD_W-1:0] pc1_cd;
  logic [3:0]        next_round;

  always_comb begin
    pc1_cd = '0;
    for (int i = 0; i < 2*CD_W; i++) begin
      pc1_cd[2*CD_W-1-i] = key_in[KEY_W-PC1[i]];
    end
  end

  assign next_round = round + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      c       <= '0;
      d       <= '0;
      round   <= '0;
      dir     <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            c       <= decrypt ? pc1_cd[2*CD_W-1:CD_W] : rotl28(pc1_cd[2*CD_W-1:CD_W], 2'd1);
            d       <= decrypt ? pc1_cd[CD_W-1:0]      : rotl28(pc1_cd[CD_W-1:0], 2'd1);
            round   <= '0;
            dir     <= decrypt;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (sk_ready) begin
            if (round == 4'(N_ROUNDS-1)) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state   <= IDLE;
            end else begin
              round  <= next_round;
              last_q <= (next_round == 4'(N_ROUNDS-1));
              c      <= dir ? rotr28(c, DEC_SHIFT[next_round]) : rotl28(c, ENC_SHIFT[next_round]);
              d      <= dir ? rotr28(d, DEC_SHIFT[next_round]) : rotl28(d, ENC_SHIFT[next_round]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = valid_q;
  assign sk_valid = valid_q;
  assign sk_last  = last_q;
  assign sk_round = round;

  des_pc2 u_pc2 (
    .cd     ({c, d}),
    .subkey (subkey)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: a bit-level DES key-schedule model
// plus a protocol tracker, checked against the DUT on every falling edge.
module tb_des_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] key_in;
  logic        decrypt;
  logic        busy;
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] subkey;
  logic [3:0]  sk_round;
  logic        sk_last;

  des_key_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .decrypt  (decrypt),
    .busy     (busy),
    .sk_valid (sk_valid),
    .sk_ready (sk_ready),
    .subkey   (subkey),
    .sk_round (sk_round),
    .sk_last  (sk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;
  logic chkEn = 1'b0;

  int pc1T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                    19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int shiftT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Key number n (1..16) straight from the DES definition: cumulative left shift of C0/D0.
  function automatic logic [47:0] refSubkey(input logic [63:0] key, input int n);
    logic c0 [28];
    logic d0 [28];
    logic cdn [56];
    logic [47:0] r;
    int s;
    s = 0;
    for (int j = 0; j < n; j++) s += shiftT[j];
    for (int i = 0; i < 28; i++) begin
      c0[i] = key[64-pc1T[i]];
      d0[i] = key[64-pc1T[i+28]];
    end
    for (int i = 0; i < 28; i++) begin
      cdn[i]    = c0[(i+s)%28];
      cdn[i+28] = d0[(i+s)%28];
    end
    r = '0;
    for (int k = 0; k < 48; k++) r[47-k] = cdn[pc2T[k]-1];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic        mBusy;
  logic [3:0]  mPos;
  logic [63:0] mKey;
  logic        mDec;
  int          hsCount = 0;
  logic [47:0] obs [16];
  logic [47:0] encObs [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy <= 1'b0;
      mPos  <= '0;
    end else if (!mBusy) begin
      if (start) begin
        mBusy <= 1'b1;
        mPos  <= '0;
        mKey  <= key_in;
        mDec  <= decrypt;
      end
    end else if (sk_ready) begin
      hsCount <= hsCount + 1;
      if (mPos == 4'd15) mBusy <= 1'b0;
      else mPos <= mPos + 4'd1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chkEn) begin
      checkOutput("busy", 64'(busy), 64'(mBusy));
      checkOutput("sk_valid", 64'(sk_valid), 64'(mBusy));
      if (mBusy) begin
        checkOutput("sk_round", 64'(sk_round), 64'(mPos));
        checkOutput("sk_last", 64'(sk_last), 64'(mPos == 4'd15));
        checkOutput("subkey", 64'(subkey),
                    64'(refSubkey(mKey, mDec ? 16 - int'(mPos) : int'(mPos) + 1)));
        obs[mPos] = subkey;
      end
    end
  end

  // mode 0: ready high, 1: random ready, 2: start pulses while busy, 3: reset at position 5
  task automatic applyStimulus(input logic [63:0] key, input logic dec, input int mode);
    int hs0;
    bit done;
    for (int i = 0; i < 16; i++) obs[i] = 'x;
    @(negedge clk);
    start = 1'b1; key_in = key; decrypt = dec; sk_ready = 1'b1;
    hs0 = hsCount;
    done = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      key_in = 64'h0;
      if (!busy) begin
        done = 1;
      end else begin
        sk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mode == 2 && (sk_round == 4'd7 || sk_round == 4'd15)) begin
          start = 1'b1; key_in = 64'hFFFF_FFFF_FFFF_FFFF; decrypt = ~dec;
        end
        if (mode == 3 && sk_round == 4'd5) begin
          #2 rst_n = 1'b0;
          #1;
          checkOutput("reset_busy", 64'(busy), 64'h0);
          checkOutput("reset_valid", 64'(sk_valid), 64'h0);
          checkOutput("reset_subkey", 64'(subkey), 64'h0);
          @(negedge clk);
          #1 rst_n = 1'b1;
          done = 1;
        end
      end
    end
    if (!done) checkOutput("run_timeout", 64'h1, 64'h0);
    if (mode != 3) checkOutput("handshakes", 64'(hsCount - hs0), 64'd16);
    sk_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; key_in = '0; decrypt = 1'b0; sk_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_valid", 64'(sk_valid), 64'h0);
    checkOutput("rst_last", 64'(sk_last), 64'h0);
    checkOutput("rst_round", 64'(sk_round), 64'h0);
    checkOutput("rst_subkey", 64'(subkey), 64'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    chkEn = 1'b1;

    checkOutput("model_k1", 64'(refSubkey(64'h133457799BBCDFF1, 1)), 64'h1B02EFFC7072);
    checkOutput("model_k2", 64'(refSubkey(64'h133457799BBCDFF1, 2)), 64'h79AED9DBC9E5);
    checkOutput("model_k16", 64'(refSubkey(64'h133457799BBCDFF1, 16)), 64'hCB3D8B0E17F5);

    applyStimulus(64'h133457799BBCDFF1, 1'b0, 0);
    checkOutput("enc_first", 64'(obs[0]), 64'h1B02EFFC7072);
    checkOutput("enc_second", 64'(obs[1]), 64'h79AED9DBC9E5);
    checkOutput("enc_last", 64'(obs[15]), 64'hCB3D8B0E17F5);
    for (int i = 0; i < 16; i++) encObs[i] = obs[i];

    applyStimulus(64'h133457799BBCDFF1, 1'b1, 0);
    checkOutput("dec_first", 64'(obs[0]), 64'hCB3D8B0E17F5);
    checkOutput("dec_last", 64'(obs[15]), 64'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) checkOutput("dec_reverse", 64'(obs[i]), 64'(encObs[15-i]));

    applyStimulus(64'h133457799BBCDFF1, 1'b0, 1);
    applyStimulus(64'h0E329232EA6D0D73, 1'b1, 1);

    applyStimulus(64'h133457799BBCDFF1, 1'b0, 2);
    checkOutput("busy_ignore_last", 64'(obs[15]), 64'hCB3D8B0E17F5);

    applyStimulus(64'h0000000000000000, 1'b0, 0);
    for (int i = 0; i < 16; i++) checkOutput("parity_zero", 64'(obs[i]), 64'h0);
    applyStimulus(64'h0101010101010101, 1'b0, 0);
    for (int i = 0; i < 16; i++) checkOutput("parity_ones", 64'(obs[i]), 64'h0);

    applyStimulus(64'h133457799BBCDFF1, 1'b0, 3);
    @(negedge clk);
    applyStimulus(64'h133457799BBCDFF1, 1'b0, 0);
    checkOutput("post_reset_first", 64'(obs[0]), 64'h1B02EFFC7072);
    checkOutput("post_reset_last", 64'(obs[15]), 64'hCB3D8B0E17F5);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
